// File: rtl/add_sub_issue_stage.sv
// Decode/issue stage feeding the add/sub execute unit: decodes add/sub-class
// instructions, forms both sources and hands them on through a 2-entry skid pipeline.
module add_sub_issue_stage #(
    parameter  int RV64      = 0,
    localparam int CPU_WIDTH = 32 * (RV64 + 1),
    localparam int OP_WIDTH  = RV64 + 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [31:0]          in_instr,
    input  logic [CPU_WIDTH-1:0] in_rs1_data,
    input  logic [CPU_WIDTH-1:0] in_rs2_data,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [OP_WIDTH-1:0]  out_op,
    output logic [CPU_WIDTH-1:0] out_s1,
    output logic [CPU_WIDTH-1:0] out_s2,
    output logic                 out_lt_req,
    output logic                 out_unsigned_flg,
    output logic [4:0]           out_rd,
    output logic                 out_hit
);

    typedef struct packed {
        logic [OP_WIDTH-1:0]  op;
        logic [CPU_WIDTH-1:0] s1;
        logic [CPU_WIDTH-1:0] s2;
        logic                 ltReq;
        logic                 unsignedFlg;
        logic [4:0]           rd;
        logic                 hit;
    } payload_t;

    logic [6:0]           opcode;
    logic [2:0]           f3;
    logic [6:0]           f7;
    logic [CPU_WIDTH-1:0] iImm;
    logic [CPU_WIDTH-1:0] sImm;
    logic [2:0]           opBits;
    payload_t             decPay;
    logic                 unusedBits;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];
    assign iImm   = {{(CPU_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
    assign sImm   = {{(CPU_WIDTH-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};

    // rs1/rs2 indices arrive already resolved as data; opBits[2] is dead on RV32.
    assign unusedBits = ^{in_instr[19:15], opBits[2]};

    always_comb begin
        opBits             = 3'b000;
        decPay             = '0;
        decPay.s1          = in_rs1_data;
        decPay.s2          = in_rs2_data;
        decPay.rd          = in_instr[11:7];
        unique case (opcode)
            7'b0110011: begin
                if (f3 == 3'b000 && f7 == 7'b0000000) begin
                    decPay.hit = 1'b1;
                    opBits[0]  = 1'b1;
                end else if (f3 == 3'b000 && f7 == 7'b0100000) begin
                    decPay.hit = 1'b1;
                    opBits[1]  = 1'b1;
                end else if (f3 == 3'b010 || f3 == 3'b011) begin
                    decPay.hit         = 1'b1;
                    opBits[1]          = 1'b1;
                    decPay.ltReq       = 1'b1;
                    decPay.unsignedFlg = f3[0];
                end
            end
            7'b0010011: begin
                if (f3 == 3'b000) begin
                    decPay.hit = 1'b1;
                    opBits[0]  = 1'b1;
                    decPay.s2  = iImm;
                end else if (f3 == 3'b010 || f3 == 3'b011) begin
                    decPay.hit         = 1'b1;
                    opBits[1]          = 1'b1;
                    decPay.s2          = iImm;
                    decPay.ltReq       = 1'b1;
                    decPay.unsignedFlg = f3[0];
                end
            end
            7'b1100011: begin
                if (f3[2]) begin
                    decPay.hit         = 1'b1;
                    opBits[1]          = 1'b1;
                    decPay.ltReq       = 1'b1;
                    decPay.unsignedFlg = f3[1];
                    decPay.rd          = 5'd0;
                end
            end
            7'b0000011: begin
                decPay.hit = 1'b1;
                opBits[0]  = 1'b1;
                decPay.s2  = iImm;
            end
            7'b0100011: begin
                decPay.hit = 1'b1;
                opBits[0]  = 1'b1;
                decPay.s2  = sImm;
                decPay.rd  = 5'd0;
            end
            7'b0111011: begin
                if (RV64 != 0 && f3 == 3'b000 && (f7 == 7'b0000000 || f7 == 7'b0100000)) begin
                    decPay.hit = 1'b1;
                    opBits[2]  = 1'b1;
                    opBits[0]  = ~f7[5];
                    opBits[1]  = f7[5];
                end
            end
            7'b0011011: begin
                if (RV64 != 0 && f3 == 3'b000) begin
                    decPay.hit = 1'b1;
                    opBits     = 3'b101;
                    decPay.s2  = iImm;
                end
            end
            default: ;
        endcase
        decPay.op = opBits[OP_WIDTH-1:0];
    end

    logic     outVld_q, outVld_d;
    logic     skidVld_q, skidVld_d;
    payload_t outPay_q, outPay_d;
    payload_t skidPay_q, skidPay_d;
    logic     accept;
    logic     outLoad;

    assign in_rdy  = ~skidVld_q;
    assign accept  = in_vld & in_rdy;
    assign outLoad = ~outVld_q | out_rdy;

    // The skid entry is older than anything arriving now, so it always refills the output first.
    always_comb begin
        outVld_d  = outVld_q;
        skidVld_d = skidVld_q;
        outPay_d  = outPay_q;
        skidPay_d = skidPay_q;
        if (flush) begin
            outVld_d  = 1'b0;
            skidVld_d = 1'b0;
        end else if (outLoad) begin
            if (skidVld_q) begin
                outVld_d  = 1'b1;
                outPay_d  = skidPay_q;
                skidVld_d = accept;
                if (accept) begin
                    skidPay_d = decPay;
                end
            end else begin
                outVld_d = accept;
                if (accept) begin
                    outPay_d = decPay;
                end
            end
        end else if (accept) begin
            skidVld_d = 1'b1;
            skidPay_d = decPay;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outVld_q  <= 1'b0;
            skidVld_q <= 1'b0;
            outPay_q  <= '0;
            skidPay_q <= '0;
        end else begin
            outVld_q  <= outVld_d;
            skidVld_q <= skidVld_d;
            outPay_q  <= outPay_d;
            skidPay_q <= skidPay_d;
        end
    end

    assign out_vld          = outVld_q;
    assign out_op           = outPay_q.op;
    assign out_s1           = outPay_q.s1;
    assign out_s2           = outPay_q.s2;
    assign out_lt_req       = outPay_q.ltReq;
    assign out_unsigned_flg = outPay_q.unsignedFlg;
    assign out_rd           = outPay_q.rd;
    assign out_hit          = outPay_q.hit;

endmodule

// File: tb/tb_add_sub_issue_stage.sv
// Directed bench for add_sub_issue_stage: an RV64 and an RV32 instance share
// control inputs; expected values are hand-computed encodings and results.
module tb_add_sub_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_vld;
    logic        out_rdy;
    logic [31:0] in_instr;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [31:0] rs1_32;
    logic [31:0] rs2_32;

    logic        rdy64, vld64, lt64, uns64, hit64;
    logic [2:0]  op64;
    logic [63:0] s1_64, s2_64;
    logic [4:0]  rd64;

    logic        rdy32, vld32, lt32, uns32, hit32;
    logic [1:0]  op32;
    logic [31:0] s1_32, s2_32;
    logic [4:0]  rd32;

    int nChecks = 0;
    int nFails  = 0;

    assign rs1_32 = rs1[31:0];
    assign rs2_32 = rs2[31:0];

    add_sub_issue_stage #(.RV64(1)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_vld(in_vld), .in_rdy(rdy64), .in_instr(in_instr),
        .in_rs1_data(rs1), .in_rs2_data(rs2),
        .out_vld(vld64), .out_rdy(out_rdy), .out_op(op64),
        .out_s1(s1_64), .out_s2(s2_64), .out_lt_req(lt64),
        .out_unsigned_flg(uns64), .out_rd(rd64), .out_hit(hit64)
    );

    add_sub_issue_stage #(.RV64(0)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_vld(in_vld), .in_rdy(rdy32), .in_instr(in_instr),
        .in_rs1_data(rs1_32), .in_rs2_data(rs2_32),
        .out_vld(vld32), .out_rdy(out_rdy), .out_op(op32),
        .out_s1(s1_32), .out_s2(s2_32), .out_lt_req(lt32),
        .out_unsigned_flg(uns32), .out_rd(rd32), .out_hit(hit32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [63:0] a, input logic [63:0] b, input logic vld);
        in_instr = instr;
        rs1      = a;
        rs2      = b;
        in_vld   = vld;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, rd, 7'b0010011};
    endfunction

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        out_rdy  = 1'b0;
        applyStimulus(32'h0, 64'h0, 64'h0, 1'b0);

        #2;
        checkOutput("rst_in_rdy", 64'(rdy64), 64'h1);
        checkOutput("rst_out_vld", 64'(vld64), 64'h0);
        checkOutput("rst_op", 64'(op64), 64'h0);
        checkOutput("rst_s1", s1_64, 64'h0);
        checkOutput("rst_s2", s2_64, 64'h0);
        checkOutput("rst_rd_hit_lt", {57'd0, rd64, hit64, lt64, uns64}, 64'h0);
        checkOutput("rst_vld32", 64'(vld32), 64'h0);

        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        out_rdy = 1'b1;

        // add x1,x2,x3
        applyStimulus(32'h003100B3, 64'd5, 64'd7, 1'b1);
        step();
        checkOutput("add_vld", 64'(vld64), 64'h1);
        checkOutput("add_op", 64'(op64), 64'h1);
        checkOutput("add_s1", s1_64, 64'd5);
        checkOutput("add_s2", s2_64, 64'd7);
        checkOutput("add_rd", 64'(rd64), 64'd1);
        checkOutput("add_hit_lt", {62'd0, hit64, lt64}, 64'h2);
        checkOutput("add_op32", 64'(op32), 64'h1);

        // addiw x1,x2,-1
        applyStimulus(32'hFFF1009B, 64'h10, 64'h99, 1'b1);
        step();
        checkOutput("addiw_op", 64'(op64), 64'h5);
        checkOutput("addiw_s1", s1_64, 64'h10);
        checkOutput("addiw_s2", s2_64, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("addiw_hit", 64'(hit64), 64'h1);
        checkOutput("addiw32_vld", 64'(vld32), 64'h1);
        checkOutput("addiw32_hit", 64'(hit32), 64'h0);
        checkOutput("addiw32_op", 64'(op32), 64'h0);

        // sltu x5,x6,x7
        applyStimulus(32'h007332B3, 64'h3, 64'h4, 1'b1);
        step();
        checkOutput("sltu_op", 64'(op64), 64'h2);
        checkOutput("sltu_lt_uns", {62'd0, lt64, uns64}, 64'h3);
        checkOutput("sltu_rd", 64'(rd64), 64'd5);
        checkOutput("sltu32_lt_uns", {62'd0, lt32, uns32}, 64'h3);

        // sub x1,x2,x3
        applyStimulus(32'h403100B3, 64'h8, 64'h2, 1'b1);
        step();
        checkOutput("sub_op", 64'(op64), 64'h2);
        checkOutput("sub_lt", 64'(lt64), 64'h0);
        checkOutput("sub_s2", s2_64, 64'h2);

        // bltu with nonzero rd field: rd forced to 0, unsigned from f3[1]
        applyStimulus(32'h0020E563, 64'h1, 64'h22, 1'b1);
        step();
        checkOutput("bltu_op", 64'(op64), 64'h2);
        checkOutput("bltu_lt_uns", {62'd0, lt64, uns64}, 64'h3);
        checkOutput("bltu_rd", 64'(rd64), 64'd0);
        checkOutput("bltu_s2", s2_64, 64'h22);

        // sw with S-imm = -4 split across both fields
        applyStimulus(32'hFE20AE23, 64'h100, 64'h55, 1'b1);
        step();
        checkOutput("sw_op", 64'(op64), 64'h1);
        checkOutput("sw_s2", s2_64, 64'hFFFF_FFFF_FFFF_FFFC);
        checkOutput("sw_rd", 64'(rd64), 64'd0);
        checkOutput("sw32_s2", 64'(s2_32), 64'hFFFF_FFFC);

        // slti x3,x1,5
        applyStimulus(32'h0050A193, 64'h9, 64'h77, 1'b1);
        step();
        checkOutput("slti_op", 64'(op64), 64'h2);
        checkOutput("slti_lt_uns", {62'd0, lt64, uns64}, 64'h2);
        checkOutput("slti_s2", s2_64, 64'd5);
        checkOutput("slti_rd", 64'(rd64), 64'd3);

        // Unsupported opcode still transfers with hit=0
        applyStimulus(32'h0000007F, 64'h1, 64'h1, 1'b1);
        step();
        checkOutput("unk_vld", 64'(vld64), 64'h1);
        checkOutput("unk_hit_op", {60'd0, hit64, op64}, 64'h0);

        applyStimulus(32'h0, 64'h0, 64'h0, 1'b0);
        step();
        checkOutput("drain_vld", 64'(vld64), 64'h0);

        // Back-pressure: A to output, B to skid, C held off
        out_rdy = 1'b0;
        applyStimulus(addi(5'd10, 12'd1), 64'hA0, 64'h0, 1'b1);
        step();
        checkOutput("bp_a_rd", 64'(rd64), 64'd10);
        checkOutput("bp_a_rdy", 64'(rdy64), 64'h1);
        applyStimulus(addi(5'd11, 12'd2), 64'hB0, 64'h0, 1'b1);
        step();
        checkOutput("bp_b_rdy", 64'(rdy64), 64'h0);
        checkOutput("bp_b_hold_rd", 64'(rd64), 64'd10);
        applyStimulus(addi(5'd12, 12'd3), 64'hC0, 64'h0, 1'b1);
        step();
        checkOutput("bp_stall_rd", 64'(rd64), 64'd10);
        checkOutput("bp_stall_s1", s1_64, 64'hA0);
        checkOutput("bp_stall_s2", s2_64, 64'd1);
        checkOutput("bp_stall_rdy", 64'(rdy64), 64'h0);
        out_rdy = 1'b1;
        step();
        checkOutput("bp_b_rd", 64'(rd64), 64'd11);
        checkOutput("bp_b_s1", s1_64, 64'hB0);
        checkOutput("bp_b_rdy2", 64'(rdy64), 64'h1);
        step();
        checkOutput("bp_c_rd", 64'(rd64), 64'd12);
        checkOutput("bp_c_s2", s2_64, 64'd3);
        applyStimulus(addi(5'd13, 12'd4), 64'hD0, 64'h0, 1'b1);
        step();
        checkOutput("bp_d_rd", 64'(rd64), 64'd13);
        checkOutput("bp_d_vld", 64'(vld64), 64'h1);
        applyStimulus(32'h0, 64'h0, 64'h0, 1'b0);
        step();
        checkOutput("bp_end_vld", 64'(vld64), 64'h0);

        // Flush with output and skid full and a new input offered
        out_rdy = 1'b0;
        applyStimulus(addi(5'd14, 12'd5), 64'hE0, 64'h0, 1'b1);
        step();
        applyStimulus(addi(5'd15, 12'd6), 64'hF0, 64'h0, 1'b1);
        step();
        checkOutput("fl_full_rdy", 64'(rdy64), 64'h0);
        flush = 1'b1;
        applyStimulus(addi(5'd16, 12'd7), 64'h160, 64'h0, 1'b1);
        step();
        checkOutput("fl_vld", 64'(vld64), 64'h0);
        checkOutput("fl_rdy", 64'(rdy64), 64'h1);
        flush   = 1'b0;
        out_rdy = 1'b1;
        applyStimulus(32'h0, 64'h0, 64'h0, 1'b0);
        step();
        checkOutput("fl_no_stale1", 64'(vld64), 64'h0);
        step();
        checkOutput("fl_no_stale2", 64'(vld64), 64'h0);
        applyStimulus(addi(5'd17, 12'd8), 64'h170, 64'h0, 1'b1);
        step();
        checkOutput("fl_after_rd", 64'(rd64), 64'd17);
        checkOutput("fl_after_vld", 64'(vld64), 64'h1);
        flush = 1'b1;
        applyStimulus(addi(5'd18, 12'd9), 64'h180, 64'h0, 1'b1);
        step();
        checkOutput("fl_accept_vld", 64'(vld64), 64'h0);
        flush = 1'b0;
        applyStimulus(32'h0, 64'h0, 64'h0, 1'b0);
        step();
        checkOutput("fl_accept_stale", 64'(vld64), 64'h0);

        // Asynchronous reset between edges with output and skid full
        out_rdy = 1'b0;
        applyStimulus(addi(5'd20, 12'd10), 64'h200, 64'h0, 1'b1);
        step();
        applyStimulus(addi(5'd21, 12'd11), 64'h210, 64'h0, 1'b1);
        step();
        checkOutput("ar_pre_rdy", 64'(rdy64), 64'h0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_vld", 64'(vld64), 64'h0);
        checkOutput("ar_rdy", 64'(rdy64), 64'h1);
        checkOutput("ar_rd", 64'(rd64), 64'h0);
        checkOutput("ar_s1", s1_64, 64'h0);
        checkOutput("ar_s2_op", {s2_64[60:0], op64}, 64'h0);
        applyStimulus(32'h0, 64'h0, 64'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        applyStimulus(addi(5'd22, 12'd12), 64'h220, 64'h0, 1'b1);
        checkOutput("ar_rel_vld", 64'(vld64), 64'h0);
        step();
        checkOutput("ar_l_vld", 64'(vld64), 64'h1);
        checkOutput("ar_l_rd", 64'(rd64), 64'd22);
        checkOutput("ar_l_s1", s1_64, 64'h220);
        applyStimulus(32'h0, 64'h0, 64'h0, 1'b0);
        step();
        checkOutput("ar_no_stale", 64'(vld64), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
